// File: rtl/vga_line_doubler.sv
// Ping-pong line buffer between the PPU pixel stream and VGA scan-out: 2x horizontal and
// 2x vertical pixel doubling, sync generation from PPU frame start. Optional macro: SCANLINE_DIM_EN.
module vga_line_doubler #(
    parameter int PIX_W    = 15,
    parameter int LINE_PIX = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ppu_pix_we,
    input  logic [7:0]       ppu_pix_x,
    input  logic [PIX_W-1:0] ppu_pix,
    input  logic             ppu_line_end,
    input  logic             ppu_frame_start,
    input  logic [9:0]       vga_next_x,
`ifdef SCANLINE_DIM_EN
    input  logic [9:0]       vga_vcounter,
`endif
    output logic [PIX_W-1:0] vga_pixel,
    output logic             vga_sync,
    output logic             overrun
);

    localparam int XW = $clog2(LINE_PIX);
    localparam int CW = PIX_W / 3;

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_RUN} state_t;

    logic [PIX_W-1:0] r_mem [0:2*LINE_PIX-1];

    logic          r_wr_bank;
    logic          r_rd_bank;
    logic          r_next_rd;
    logic          r_swap_pend;
    logic          r_overrun;
    logic [PIX_W-1:0] r_pix_p1;
    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_sync;
    logic          w_boundary;
    logic          w_swap;
    logic          w_rd_bank;
    logic [XW:0]   w_wr_addr;
    logic [XW:0]   w_rd_addr;
    logic          w_unused;

`ifdef SCANLINE_DIM_EN
    function automatic logic [PIX_W-1:0] dim_half(input logic [PIX_W-1:0] p);
        logic [PIX_W-1:0] m;
        m = '1;
        for (int c = 0; c < 3; c++) m[c*CW + CW - 1] = 1'b0;
        return (p >> 1) & m;
    endfunction

    assign w_unused = ^{vga_next_x[9], vga_vcounter[9:1]};
`else
    assign w_unused = vga_next_x[9];
`endif

    assign w_boundary = (vga_next_x[8:0] == 9'd0);
    assign w_swap     = r_swap_pend & w_boundary;
    // Pixel 0 of a new VGA line already comes from the freshly swapped bank.
    assign w_rd_bank  = w_swap ? r_next_rd : r_rd_bank;
    assign w_wr_addr  = {r_wr_bank, ppu_pix_x[XW-1:0]};
    assign w_rd_addr  = {w_rd_bank, vga_next_x[XW:1]};

    always_ff @(posedge clk) begin
        if (ppu_pix_we) r_mem[w_wr_addr] <= ppu_pix;
    end

    // Stage p0 -> p1: RAM read, optional scanline dimming, registered output.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_p1 <= '0;
        end else begin
`ifdef SCANLINE_DIM_EN
            r_pix_p1 <= vga_vcounter[0] ? dim_half(r_mem[w_rd_addr]) : r_mem[w_rd_addr];
`else
            r_pix_p1 <= r_mem[w_rd_addr];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_next_rd   <= 1'b0;
            r_swap_pend <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_swap) r_rd_bank <= r_next_rd;
            if (ppu_frame_start) begin
                r_wr_bank   <= 1'b0;
                r_swap_pend <= 1'b0;
            end else if (ppu_line_end) begin
                r_wr_bank   <= ~r_wr_bank;
                r_next_rd   <= r_wr_bank;
                r_swap_pend <= 1'b1;
                // A pending swap not consumed this cycle is lost; the newer line wins.
                if (r_swap_pend && !w_boundary) r_overrun <= 1'b1;
            end else if (w_swap) begin
                r_swap_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sync      = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (ppu_frame_start) w_state_nxt = S_PULSE;
            end
            S_PULSE: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_sync = 1'b0;
                if (ppu_frame_start) w_state_nxt = S_PULSE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign vga_pixel = r_pix_p1;
    assign vga_sync  = w_sync;
    assign overrun   = r_overrun;

endmodule

// File: doc/vga_line_doubler.md
Name: vga_line_doubler

Overview:
- Upstream neighbour of the VGA driver: ping-pong line buffer between the NES PPU pixel stream and the VGA scan-out.
- Captures one 256-pixel PPU line per bank. Serves each stored pixel twice horizontally (512 VGA pixels) and each line on two VGA lines.
- Generates the driver's sync pulse from PPU frame start.
- Flags line overruns.

Parameters:
- PIX_W, 15, pixel width; {B[14:10], G[9:5], R[4:0]}, same packing the VGA driver consumes.
- LINE_PIX, 256, PPU pixels per line (bank depth); must be a power of 2.

Ports:
- clk  in  1  system clock, shared with the VGA driver.
- reset  in  1  synchronous, active-high reset.
- ppu_pix_we  in  1  write strobe for ppu_pix at ppu_pix_x.
- ppu_pix_x  in  8  PPU column 0..255.
- ppu_pix  in  PIX_W  PPU pixel colour.
- ppu_line_end  in  1  one-cycle pulse after the last pixel of a PPU line.
- ppu_frame_start  in  1  one-cycle pulse at the start of PPU line 0.
- vga_next_x  in  10  driver's next_pixel_x; bits [8:0] used, bit 9 ignored.
- vga_pixel  out  PIX_W  registered pixel for the current VGA cycle.
- vga_sync  out  1  to the driver's sync input.
- overrun  out  1  sticky line-overrun flag.

Behaviour:
- Storage: 2 banks x LINE_PIX x PIX_W, inferred block RAM, one write port and one read port. Reset does not clear it.
- Write path:
  - While ppu_pix_we=1, mem[{wr_bank, ppu_pix_x}] <= ppu_pix.
  - wr_bank resets to 0.
- Line end: on ppu_line_end, wr_bank toggles, swap_pend <= 1, and next_rd <= the old wr_bank.
- Bank swap: when swap_pend=1 and vga_next_x[8:0]==0, rd_bank <= next_rd and swap_pend <= 0. Swaps only at a VGA line boundary, never mid-line.
- Simultaneous events:
  - ppu_line_end and a boundary in the same cycle: the boundary consumes the old pending swap first, then the new swap is pended.
  - ppu_line_end while swap_pend=1 and no boundary: overrun <= 1 and the newer bank wins (next_rd updated).
- Read path:
  - vga_pixel <= mem[{rd_bank, vga_next_x[8:1]}]; 1-cycle latency, matching the driver's "pixel we need NEXT cycle".
  - Read-during-write to the same address returns old data.
- Sync FSM:
  - States: IDLE, PULSE, RUN.
  - Reset enters IDLE, with vga_sync=1 so the driver's counters are held at 0.
  - IDLE: on ppu_frame_start -> PULSE.
  - PULSE: vga_sync=1 for exactly one cycle, then -> RUN.
  - RUN: vga_sync=0. On ppu_frame_start -> PULSE. The driver's v=0 then coincides with PPU line 0 within 2 cycles.
- ppu_frame_start also resets wr_bank to 0 and clears swap_pend. ppu_frame_start has priority over a simultaneous ppu_line_end.
- Reset values: vga_pixel=0, vga_sync=1, overrun=0, rd_bank=0, wr_bank=0, next_rd=0, swap_pend=0, state=IDLE.
- Reset mid-line: all registers return to reset values on the next clock; any partially written line is discarded logically.
- Overrun clears only on reset.

Optional Feature:
- Macro: SCANLINE_DIM_EN.
- Defined:
  - Adds input vga_vcounter[9:0].
  - On odd VGA lines (vga_vcounter[0]=1), each 5-bit channel of vga_pixel is halved (logical shift right by 1). Same 1-cycle latency.
  - vga_vcounter is sampled in the same cycle as the RAM read.
- Undefined: port absent; pixels pass unmodified.

Test Plan:
- Reset held 3 cycles -> vga_sync=1, vga_pixel=0, overrun=0. Release, then ppu_frame_start -> vga_sync stays 1 one more cycle, then 0 (state RUN).
- Write x=0..255 with pixel=x into bank 0, pulse ppu_line_end, sweep vga_next_x[8:0]=0..511 -> the swap occurs at vga_next_x[8:0]=0; vga_pixel one cycle later equals vga_next_x>>1, e.g. 0,0,1,1,...,255,255.
- Two ppu_line_end pulses with no vga_next_x[8:0]==0 between them -> overrun=1 and stays 1 through the following ppu_frame_start; read bank is the second completed line.
- ppu_line_end in the same cycle as vga_next_x[8:0]==0 with swap_pend=1 -> first pending swap taken, swap_pend remains 1 for the new line; overrun=0.
- Write the address currently being read (wr_bank==rd_bank forced via frame_start) -> vga_pixel shows old value that cycle, new value on the next read.
- SCANLINE_DIM_EN defined: pixel 15'h7FFF, vga_vcounter=1 -> vga_pixel=15'h3DEF; vga_vcounter=2 -> 15'h7FFF.
